// File: rtl/pencase_pkg.sv
// Shared definitions for the pencase vending controller.
//   state_t      : controller FSM encoding
//   RSN_*        : reject reason codes driven on reject_reason
//   NONE/RED/BLUE: colour values ("no product" and the named products)
//   num_colors() : number of real colours for a given colour width
package pencase_pkg;

  typedef enum logic [1:0] {
    COLLECT  = 2'd0,
    DECIDE   = 2'd1,
    DISPENSE = 2'd2,
    REJECT   = 2'd3
  } state_t;

  localparam logic [1:0] RSN_NONE    = 2'b00;
  localparam logic [1:0] RSN_NOPROD  = 2'b01;
  localparam logic [1:0] RSN_SOLDOUT = 2'b10;

  localparam int NONE = 0;
  localparam int RED  = 1;
  localparam int BLUE = 2;

  // Colour 0 means "no product", so only 2^color_w-1 colours carry stock.
  function automatic int num_colors(input int color_w);
    return (1 << color_w) - 1;
  endfunction

endpackage

// File: rtl/pencase_stock.sv
// Per-colour stock bank: one saturating STOCK_W counter per real colour.
// Ports:
//   clock, n_rst   : clock, asynchronous active-low reset (loads STOCK_INIT)
//   restock_en     : add restock_qty to restock_color (colour 0 ignored)
//   restock_color  : colour being restocked
//   restock_qty    : quantity added, result saturates at all-ones
//   dec_en         : take one item of dec_color (caller guarantees stock > 0)
//   dec_color      : colour being sold
//   sold_out       : bit i-1 set while colour i has zero stock (from registers)
module pencase_stock
  import pencase_pkg::*;
#(
  parameter int COLOR_W    = 2,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 9
) (
  input  logic                       clock,
  input  logic                       n_rst,
  input  logic                       restock_en,
  input  logic [COLOR_W-1:0]         restock_color,
  input  logic [STOCK_W-1:0]         restock_qty,
  input  logic                       dec_en,
  input  logic [COLOR_W-1:0]         dec_color,
  output logic [(2**COLOR_W)-2:0]    sold_out
);

  localparam int NCOL = num_colors(COLOR_W);

  logic [NCOL:1][STOCK_W-1:0] stock_q;
  logic [NCOL:1][STOCK_W-1:0] stock_d;

  // Restock and sale on the same colour in one cycle combine as
  // sat(stock + qty) - 1. The sale was only allowed because the
  // pre-restock value was non-zero, so the decrement cannot underflow.
  always_comb begin
    logic [STOCK_W:0]   sum;
    logic [STOCK_W:0]   add;
    logic [STOCK_W-1:0] sat;
    stock_d = stock_q;
    sum     = '0;
    add     = '0;
    sat     = '0;
    for (int i = 1; i <= NCOL; i++) begin
      add = (restock_en && restock_color == COLOR_W'(i)) ? {1'b0, restock_qty} : '0;
      sum = {1'b0, stock_q[i]} + add;
      sat = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
      if (dec_en && dec_color == COLOR_W'(i)) begin
        sat = sat - STOCK_W'(1);
      end
      stock_d[i] = sat;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      stock_q <= {NCOL{STOCK_W'(STOCK_INIT)}};
    end else begin
      stock_q <= stock_d;
    end
  end

  always_comb begin
    sold_out = '0;
    for (int i = 1; i <= NCOL; i++) begin
      sold_out[i-1] = (stock_q[i] == '0);
    end
  end

endmodule

// File: rtl/pencase_vend_seq.sv
// Serial-code vending controller for the pencase dispenser.
// A CODE_W-bit code arrives MSB first, one bit per coin_valid strobe, and is
// looked up in a run-time programmable code->colour table. The result is a
// held dispense request, or a one-cycle reject with a reason code.
// Ports:
//   clock, n_rst   : clock, asynchronous active-low reset
//   start          : synchronous abort/restart back to COLLECT
//   coin_valid/coin: serial code bit strobe and data (ignored while busy)
//   prog_en/prog_code/prog_color         : table write, visible next cycle
//   restock_en/restock_color/restock_qty : saturating stock add
//   disp_ack       : dispenser took the item
//   busy           : high outside COLLECT
//   color          : colour being dispensed, else 0
//   disp_req       : dispense request
//   reject/reject_reason : one-cycle reject pulse and its reason
//   sold_out       : bit i-1 set when colour i is out of stock
//
// Dispense handshake: disp_req rises with color valid and both stay stable
// until the clock edge where disp_ack is sampled high; both drop after that
// edge. disp_ack is ignored unless disp_req is high.
module pencase_vend_seq
  import pencase_pkg::*;
#(
  parameter int CODE_W     = 3,
  parameter int COLOR_W    = 2,
  parameter int STOCK_W    = 4,
  parameter int STOCK_INIT = 9
) (
  input  logic                    clock,
  input  logic                    n_rst,
  input  logic                    start,
  input  logic                    coin_valid,
  input  logic                    coin,
  input  logic                    prog_en,
  input  logic [CODE_W-1:0]       prog_code,
  input  logic [COLOR_W-1:0]      prog_color,
  input  logic                    restock_en,
  input  logic [COLOR_W-1:0]      restock_color,
  input  logic [STOCK_W-1:0]      restock_qty,
  input  logic                    disp_ack,
  output logic                    busy,
  output logic [COLOR_W-1:0]      color,
  output logic                    disp_req,
  output logic                    reject,
  output logic [1:0]              reject_reason,
  output logic [(2**COLOR_W)-2:0] sold_out
);

  localparam int DEPTH = 1 << CODE_W;
  localparam int NCOL  = num_colors(COLOR_W);
  localparam int CNT_W = $clog2(CODE_W + 1);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [CODE_W-1:0]  shreg;
  logic [COLOR_W-1:0] code_table [DEPTH];

  logic [COLOR_W-1:0] look_color;
  logic [NCOL:0]      so_ext;
  logic               dec_en;

  // Table read uses the registered contents, so a write landing in the
  // DECIDE cycle returns the old entry.
  assign look_color = code_table[shreg];

  // sold_out re-indexed by colour value; slot 0 (no product) is never used.
  assign so_ext = {sold_out, 1'b0};

  // start aborts DECIDE before any stock is taken.
  assign dec_en = (state == DECIDE) && !start &&
                  (look_color != '0) && !so_ext[look_color];

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        code_table[i] <= '0;
      end
    end else if (prog_en) begin
      code_table[prog_code] <= prog_color;
    end
  end

  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state         <= COLLECT;
      bit_cnt       <= '0;
      shreg         <= '0;
      busy          <= 1'b0;
      color         <= COLOR_W'(NONE);
      disp_req      <= 1'b0;
      reject        <= 1'b0;
      reject_reason <= RSN_NONE;
    end else if (start) begin
      state         <= COLLECT;
      bit_cnt       <= '0;
      shreg         <= '0;
      busy          <= 1'b0;
      color         <= COLOR_W'(NONE);
      disp_req      <= 1'b0;
      reject        <= 1'b0;
      reject_reason <= RSN_NONE;
    end else begin
      case (state)
        COLLECT: begin
          if (coin_valid) begin
            shreg   <= CODE_W'({shreg, coin});
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(CODE_W - 1)) begin
              state <= DECIDE;
              busy  <= 1'b1;
            end
          end
        end
        DECIDE: begin
          if (look_color == '0) begin
            state         <= REJECT;
            reject        <= 1'b1;
            reject_reason <= RSN_NOPROD;
          end else if (so_ext[look_color]) begin
            state         <= REJECT;
            reject        <= 1'b1;
            reject_reason <= RSN_SOLDOUT;
          end else begin
            state    <= DISPENSE;
            disp_req <= 1'b1;
            color    <= look_color;
          end
        end
        DISPENSE: begin
          if (disp_ack) begin
            state    <= COLLECT;
            bit_cnt  <= '0;
            busy     <= 1'b0;
            disp_req <= 1'b0;
            color    <= COLOR_W'(NONE);
          end
        end
        REJECT: begin
          state         <= COLLECT;
          bit_cnt       <= '0;
          busy          <= 1'b0;
          reject        <= 1'b0;
          reject_reason <= RSN_NONE;
        end
        default: begin
          state <= COLLECT;
        end
      endcase
    end
  end

  pencase_stock #(
    .COLOR_W    (COLOR_W),
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .clock         (clock),
    .n_rst         (n_rst),
    .restock_en    (restock_en),
    .restock_color (restock_color),
    .restock_qty   (restock_qty),
    .dec_en        (dec_en),
    .dec_color     (look_color),
    .sold_out      (sold_out)
  );

endmodule

// File: doc/pencase_vend_seq.md
Name: pencase_vend_seq

Overview:
- Parametrised serial-code vending controller for the pencase dispenser.
- A CODE_W-bit code arrives one bit per coin_valid strobe and is looked up in a run-time programmable code→colour table.
- Per-colour stock is tracked; the block then issues a held dispense request or a one-cycle reject with a reason.
- Sits between the coin/keypad front end and the dispenser mechanism.

Parameters:
- CODE_W, 3: bits per code; table depth is 2^CODE_W.
- COLOR_W, 2: colour width. Value 0 means no product; colours are 1..2^COLOR_W-1 (1 = RED, 2 = BLUE).
- STOCK_W, 4: per-colour stock counter width.
- STOCK_INIT, 9: stock value loaded into every colour at reset.

Ports:
- clock  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  synchronous abort/restart.
- coin_valid  in  1  qualifies coin.
- coin  in  1  serial code bit, MSB first.
- prog_en  in  1  table write strobe.
- prog_code  in  CODE_W  table entry to write.
- prog_color  in  COLOR_W  colour written to that entry; 0 = none.
- restock_en  in  1  restock strobe.
- restock_color  in  COLOR_W  colour to restock; 0 = ignored.
- restock_qty  in  STOCK_W  quantity added.
- disp_ack  in  1  dispenser has taken the item.
- busy  out  1  high in any state other than COLLECT; bits are dropped while high.
- color  out  COLOR_W  colour being dispensed, else 0.
- disp_req  out  1  dispense request, held until ack.
- reject  out  1  one-cycle reject pulse.
- reject_reason  out  2  01 = no product for code, 10 = sold out; valid while reject=1, else 00.
- sold_out  out  2^COLOR_W-1  bit i-1 set when stock[i]==0.

Behaviour:
- Reset (n_rst=0, async):
  - state=COLLECT, bit count=0, shift register=0.
  - All table entries=0; all stock=STOCK_INIT.
  - color, disp_req, reject, reject_reason, busy all 0.
- Priority at each edge: n_rst, then start, then normal operation.
- start=1:
  - Next state COLLECT, count=0, shift register cleared.
  - disp_req, color and reject drop after the edge.
  - Table and stock are untouched; a stock decrement already taken is not refunded.
- COLLECT:
  - Each cycle with coin_valid=1 shifts coin into the LSB (MSB-first overall) and increments the count.
  - Cycles without coin_valid hold state; there is no timeout.
  - When the CODE_W-th bit is accepted at edge k, state goes to DECIDE.
- DECIDE (1 cycle): c = table[code].
  - c==0: go to REJECT, reason 01.
  - stock[c]==0: go to REJECT, reason 10.
  - Otherwise: stock[c] decrements, color register <= c, go to DISPENSE.
  - disp_req or reject is therefore visible after edge k+1 (2-cycle latency from last bit).
- DISPENSE:
  - disp_req=1 and color=c are held while disp_ack=0.
  - On the edge where disp_ack=1: go to COLLECT with count=0; color and disp_req become 0.
  - disp_ack outside DISPENSE is ignored.
- REJECT (1 cycle): reject=1 with reason; then COLLECT with count=0.
- coin_valid outside COLLECT is dropped, not queued.
- All outputs are registered / Moore-decoded from state; none depend combinationally on inputs.
- Table programming:
  - prog_en writes table[prog_code] <= prog_color in any state, effective the next cycle.
  - A same-cycle write to the entry being read in DECIDE returns the old value.
- Restock:
  - stock[rc] <= min(stock + qty, 2^STOCK_W-1), saturating.
  - If the restock hits the colour being decremented in the same DECIDE cycle: new = sat(stock + qty) - 1, and the sold-out check uses the pre-restock value.
- sold_out is combinational from the stock registers.

Decomposition:
- Package pencase_pkg holds:
  - State encoding (COLLECT, DECIDE, DISPENSE, REJECT).
  - Reason constants (RSN_NONE=00, RSN_NOPROD=01, RSN_SOLDOUT=10).
  - Colour constants (NONE=0, RED=1, BLUE=2).
- Sub-module pencase_stock: bank of 2^COLOR_W-1 saturating STOCK_W counters. It provides restock, decrement and simultaneous-op handling, and produces sold_out.
- The table and FSM live in pencase_vend_seq.

Test Plan:
- Program 001→1; send bits 0,0,1 with gaps between strobes.
  - Required: disp_req=1, color=01 two cycles after the last bit, held 5 cycles until disp_ack; then both 0; stock[1] goes 9→8.
- Send code 111 (unprogrammed).
  - Required: reject=1 for exactly one cycle, reason=01, disp_req never asserts, stock unchanged.
- Program 010→2; buy 9 times.
  - Required: the 10th attempt gives reject reason=10 and sold_out[1]=1.
  - Then restock color 2, qty 3: stock=3, sold_out[1]=0, and the next buy dispenses.
- start after 2 bits, then send 0,0,1.
  - Required: decoded as 001 → RED.
  - Also: start during DISPENSE drops disp_req the next cycle, and the decremented stock stays decremented.
- Bits pulsed during DISPENSE/REJECT are ignored (busy=1); the next code starts clean.
- Restock qty 15 on stock 9: stock saturates at 15.
- Restock colour 1 in the same DECIDE cycle as a colour-1 buy with stock 0:
  - Required: reject reason 10, stock becomes qty.
- Async n_rst mid-DISPENSE: all outputs 0 immediately, table cleared, stock=9.
